// File: rtl/code_entry_pkg.sv
// Shared types and constants for the code entry checker.
// Seven-segment patterns are active-low, bit 6 = segment g.
package code_entry_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    MATCH,
    MISMATCH,
    LOCKOUT
  } state_e;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_ONE   = 7'b1111001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_digit(input logic b);
    return b ? SEG_ONE : SEG_ZERO;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Push-button synchroniser with falling-edge press detector.
// Two sync flops plus one history flop; all idle high.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic press_o
);

  logic [2:0] sync_q;

  // shift the raw pin through sync stages and edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 3'b111;
    else        sync_q <= {sync_q[1:0], btn_n_i};
  end

  assign press_o = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/code_entry_checker.sv
// Serial binary code lock: compares button-entered bits
// against a switch-loaded target, with hold and lockout timers.
module code_entry_checker
  import code_entry_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter int          EARLY_ABORT = 1,
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int          MAX_FAIL    = 3,
  parameter int unsigned LOCK_CYCLES = 500_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [WIDTH-1:0]   switch,
  input  logic               select,
  input  logic               button0,
  input  logic               button1,
  output logic [7*WIDTH-1:0] seg,
  output logic               LED_G,
  output logic               LED_R,
  output logic               locked
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int unsigned TMAX =
    (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [FW-1:0] FAIL_LIM  = FW'(MAX_FAIL);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] entry_q, entry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [FW-1:0]    fail_q, fail_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic             p0, p1, press, pbit;
  logic             exp_bit;
  logic [WIDTH-1:0] ins_entry;
  logic [TW-1:0]    timer_inc;
  logic [FW-1:0]    fail_inc;

  btn_edge u_btn0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n_i (button0),
    .press_o (p0)
  );

  btn_edge u_btn1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n_i (button1),
    .press_o (p1)
  );

  // simultaneous presses cancel out
  assign press = p0 ^ p1;
  assign pbit  = p1;

  assign timer_inc = (timer_q == '1) ? timer_q
                                     : timer_q + TW'(1);
  assign fail_inc  = fail_q + FW'(1);

  // target bit for the next slot and entry with that slot filled
  always_comb begin
    exp_bit   = 1'b0;
    ins_entry = entry_q;
    for (int k = 0; k < WIDTH; k++) begin
      if (k == WIDTH - 1 - int'(count_q)) begin
        exp_bit      = target_q[k];
        ins_entry[k] = pbit;
      end
    end
  end

  // next-state logic; enable overrides everything but lockout
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    entry_d  = entry_q;
    count_d  = count_q;
    fail_d   = fail_q;
    timer_d  = timer_q;
    if (enable && state_q != LOCKOUT) begin
      state_d  = IDLE;
      target_d = switch;
      entry_d  = '0;
      count_d  = '0;
      fail_d   = '0;
      timer_d  = '0;
    end else begin
      unique case (state_q)
        IDLE, ENTRY: begin
          if (press) begin
            entry_d = ins_entry;
            count_d = count_q + CW'(1);
            timer_d = '0;
            state_d = ENTRY;
            if (EARLY_ABORT != 0 && pbit != exp_bit)
              state_d = MISMATCH;
            else if (count_q == CNT_LAST)
              state_d = (ins_entry == target_q) ? MATCH
                                                : MISMATCH;
          end
        end
        MATCH: begin
          if (timer_q == HOLD_LAST) begin
            state_d = IDLE;
            entry_d = '0;
            count_d = '0;
            fail_d  = '0;
            timer_d = '0;
          end else begin
            timer_d = timer_inc;
          end
        end
        MISMATCH: begin
          if (timer_q == HOLD_LAST) begin
            entry_d = '0;
            count_d = '0;
            timer_d = '0;
            fail_d  = fail_inc;
            state_d = (fail_inc == FAIL_LIM) ? LOCKOUT : IDLE;
          end else begin
            timer_d = timer_inc;
          end
        end
        LOCKOUT: begin
          if (timer_q == LOCK_LAST) begin
            state_d = IDLE;
            fail_d  = '0;
            timer_d = '0;
          end else begin
            timer_d = timer_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      entry_q  <= '0;
      count_q  <= '0;
      fail_q   <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      entry_q  <= entry_d;
      count_q  <= count_d;
      fail_q   <= fail_d;
      timer_q  <= timer_d;
    end
  end

  // digit k shows bit k; unentered slots are blank
  always_comb begin
    seg = '1;
    for (int k = 0; k < WIDTH; k++) begin
      if (select)
        seg[7*k +: 7] = seg_digit(target_q[k]);
      else if (WIDTH - 1 - k < int'(count_q))
        seg[7*k +: 7] = seg_digit(entry_q[k]);
      else
        seg[7*k +: 7] = SEG_BLANK;
    end
  end

  assign LED_G  = (state_q == MATCH);
  assign LED_R  = (state_q == MISMATCH) || (state_q == LOCKOUT);
  assign locked = (state_q == LOCKOUT);

endmodule

// File: tb/tb_code_entry_checker.sv
// Self-checking bench for code_entry_checker.
// Directed scenarios plus random codes against a queue-based model.
module tb_code_entry_checker;

  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] DB = 7'b1111111;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic        en = 0, sel = 0, b0 = 1, b1 = 1;
  logic [7:0]  sw = 0;
  logic [55:0] seg;
  logic        g, r, lk;

  logic        en_x = 0, sel_x = 0, b0_x = 1, b1_x = 1;
  logic [7:0]  sw_x = 0;
  logic [55:0] seg_x;
  logic        g_x, r_x, lk_x;

  always #5 clk = ~clk;

  code_entry_checker #(
    .WIDTH(8), .EARLY_ABORT(1), .HOLD_CYCLES(4),
    .MAX_FAIL(3), .LOCK_CYCLES(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(en), .switch(sw),
    .select(sel), .button0(b0), .button1(b1), .seg(seg),
    .LED_G(g), .LED_R(r), .locked(lk)
  );

  code_entry_checker #(
    .WIDTH(8), .EARLY_ABORT(0), .HOLD_CYCLES(4),
    .MAX_FAIL(3), .LOCK_CYCLES(10)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en_x), .switch(sw_x),
    .select(sel_x), .button0(b0_x), .button1(b1_x), .seg(seg_x),
    .LED_G(g_x), .LED_R(r_x), .locked(lk_x)
  );

  int nchk = 0;
  int nfail = 0;

  logic [7:0] m_tgt = 8'h00;
  bit         m_ent[$];
  int         m_fails = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] exp_seg(bit s);
    logic [55:0] v;
    int p;
    v = '1;
    for (int k = 0; k < 8; k++) begin
      p = 7 - k;
      if (s)
        v[7*k +: 7] = m_tgt[k] ? D1 : D0;
      else if (p < m_ent.size())
        v[7*k +: 7] = m_ent[p] ? D1 : D0;
      else
        v[7*k +: 7] = DB;
    end
    return v;
  endfunction

  task automatic check_seg(string tag);
    sel = 0;
    #1 chk({tag, "_entry"}, seg, exp_seg(0));
    sel = 1;
    #1 chk({tag, "_target"}, seg, exp_seg(1));
    sel = 0;
  endtask

  task automatic load(int d, logic [7:0] t);
    @(negedge clk);
    if (d == 0) begin en = 1; sw = t; end
    else begin en_x = 1; sw_x = t; end
    @(negedge clk);
    en = 0;
    en_x = 0;
    if (d == 0) begin
      m_tgt = t;
      m_ent.delete();
      m_fails = 0;
    end
  endtask

  // returns at #1 after the edge on which the press takes effect
  task automatic press(int d, bit b, bit both);
    repeat (3) @(negedge clk);
    if (d == 0) begin
      if (b || both) b1 = 0;
      if (!b || both) b0 = 0;
    end else begin
      if (b) b1_x = 0;
      else   b0_x = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    b0 = 1; b1 = 1; b0_x = 1; b1_x = 1;
  endtask

  task automatic measure(int d, bit poke,
                         output int cg, output int cr, output int cl);
    logic vg, vr, vl;
    int i;
    cg = 0; cr = 0; cl = 0; i = 0;
    while (i < 60) begin
      vg = d ? g_x : g;
      vr = d ? r_x : r;
      vl = d ? lk_x : lk;
      if (!(vg || vr || vl)) break;
      cg += int'(vg);
      cr += int'(vr);
      cl += int'(vl);
      if (poke && i == 6) begin en = 1; sw = ~m_tgt; b0 = 0; end
      if (poke && i == 8) begin en = 0; b0 = 1; end
      @(posedge clk);
      #1;
      i++;
    end
    if (d == 0) chk("meas_end", {g, r, lk}, 3'b000);
    else        chk("meas_end_x", {g_x, r_x, lk_x}, 3'b000);
  endtask

  // enter one bit on the early-abort unit and check the outcome
  task automatic enter_bit(bit b, output int oc);
    int idx, cg, cr, cl;
    press(0, b, 0);
    m_ent.push_back(b);
    idx = m_ent.size() - 1;
    oc = 0;
    if (b != m_tgt[7 - idx]) oc = 2;
    else if (m_ent.size() == 8) oc = 1;
    if (oc == 0) begin
      chk("leds_entry", {g, r, lk}, 3'b000);
      check_seg("seg_entry");
    end else if (oc == 1) begin
      chk("match_edge", {g, r, lk}, 3'b100);
      measure(0, 0, cg, cr, cl);
      chk("match_g", cg, 4);
      chk("match_r", cr, 0);
      m_fails = 0;
      m_ent.delete();
      check_seg("seg_after_match");
    end else begin
      chk("mism_edge", {g, r, lk}, 3'b010);
      m_fails++;
      measure(0, m_fails == 3, cg, cr, cl);
      chk("mism_g", cg, 0);
      if (m_fails == 3) begin
        chk("lock_r", cr, 14);
        chk("lock_l", cl, 10);
        m_fails = 0;
      end else begin
        chk("mism_r", cr, 4);
        chk("mism_l", cl, 0);
      end
      m_ent.delete();
      check_seg("seg_after_mism");
    end
  endtask

  initial begin
    int oc, cg, cr, cl, lit;
    logic [7:0] code;

    // reset state
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_leds", {g, r, lk}, 3'b000);
    check_seg("rst");
    @(negedge clk);
    rst_n = 1;

    // press latency: update on the third edge after pin falls
    load(0, 8'hA5);
    check_seg("load_a5");
    repeat (3) @(negedge clk);
    b1 = 0;
    repeat (2) @(posedge clk);
    #1;
    sel = 0;
    #1 chk("lat_edge2", seg[55:49], DB);
    @(posedge clk);
    #1;
    b1 = 1;
    chk("lat_edge3", seg[55:49], D1);
    m_ent.push_back(1'b1);
    check_seg("lat");

    // rest of 0xA5 -> match
    code = 8'hA5;
    for (int i = 1; i < 8; i++) enter_bit(code[7 - i], oc);
    chk("a5_outcome", oc, 1);

    // early abort on second bit
    enter_bit(1'b1, oc);
    enter_bit(1'b1, oc);
    chk("abort_outcome", oc, 2);
    chk("fail_cnt_1", dut.fail_q, m_fails);

    // two more failures -> lockout with pokes ignored
    enter_bit(1'b0, oc);
    chk("fail_cnt_2", dut.fail_q, m_fails);
    enter_bit(1'b0, oc);
    chk("fail_cnt_lock", dut.fail_q, m_fails);

    // simultaneous buttons, then enable mid-entry
    enter_bit(1'b1, oc);
    enter_bit(1'b0, oc);
    press(0, 1'b0, 1);
    chk("both_leds", {g, r, lk}, 3'b000);
    check_seg("both");
    load(0, 8'h3C);
    check_seg("en_mid");
    enter_bit(1'b0, oc);
    chk("en_mid_outcome", oc, 0);

    // full-code check only: mismatch after the 8th bit
    load(1, 8'hA5);
    code = 8'hA4;
    for (int i = 0; i < 8; i++) begin
      press(1, code[7 - i], 0);
      if (i < 7) chk("late_no_led", {g_x, r_x}, 2'b00);
      else       chk("late_mism", {g_x, r_x}, 2'b01);
    end
    measure(1, 0, cg, cr, cl);
    chk("late_r", cr, 4);

    // random targets and codes
    for (int t = 0; t < 14; t++) begin
      if (t == 0 || $urandom_range(0, 2) == 0) begin
        load(0, 8'($urandom));
        check_seg("rnd_load");
      end
      code = ($urandom_range(0, 1) == 0) ? m_tgt : 8'($urandom);
      for (int i = 0; i < 8; i++) begin
        enter_bit(code[7 - i], oc);
        if (oc != 0) break;
      end
    end

    // async reset in the middle of a match
    load(0, 8'h5A);
    code = 8'h5A;
    for (int i = 0; i < 8; i++) press(0, code[7 - i], 0);
    chk("pre_rst_match", {g, r, lk}, 3'b100);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("arst_leds", {g, r, lk}, 3'b000);
    m_tgt = 8'h00;
    m_ent.delete();
    m_fails = 0;
    check_seg("arst");
    repeat (2) @(negedge clk);
    rst_n = 1;
    lit = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 lit += int'(g || r || lk);
    end
    chk("post_rst_quiet", lit, 0);
    check_seg("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/code_entry_checker.md
CODE_ENTRY_CHECKER -- requirements
Module: code_entry_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 8, code length in bits (legal 2..16).
REQ-002 SHALL have parameter EARLY_ABORT, default 1; 1 = check each bit as entered, 0 = check only on the full code.
REQ-003 SHALL have parameter HOLD_CYCLES, default 50_000_000, cycles a result LED stays lit.
REQ-004 SHALL have parameter MAX_FAIL, default 3, consecutive failures before lockout.
REQ-005 SHALL have parameter LOCK_CYCLES, default 500_000_000, lockout duration in cycles.
REQ-006 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-008 SHALL have port enable, input, 1, level; loads switch into target.
REQ-009 SHALL have port switch, input, WIDTH, target code source.
REQ-010 SHALL have port select, input, 1; 1 = display target, 0 = display entry.
REQ-011 SHALL have port button0, input, 1, active-low asynchronous push button that enters a 0.
REQ-012 SHALL have port button1, input, 1, active-low asynchronous push button that enters a 1.
REQ-013 SHALL have port seg, output, 7*WIDTH, one digit per bit, active-low; digit k at seg[7k+6:7k] shows bit k.
REQ-014 SHALL have port LED_G, output, 1, match indicator.
REQ-015 SHALL have port LED_R, output, 1, mismatch or lockout indicator.
REQ-016 SHALL have port locked, output, 1, high throughout LOCKOUT.

Function
REQ-017 SHALL pass each button through a 2-flop synchroniser plus an edge flop, and produce a 1-cycle press pulse on the high-to-low transition.
REQ-018 SHALL update entry/count on the 3rd rising clk edge after the button pin goes low.
REQ-019 SHALL use FSM states IDLE, ENTRY, MATCH, MISMATCH, LOCKOUT.
REQ-020 SHALL, on a press pulse in IDLE or ENTRY, write the bit to entry[WIDTH-1-count] (MSB first), increment count, and move IDLE->ENTRY.
REQ-021 SHALL ignore both pulses when they occur in the same cycle: no bit entered, no count change.
REQ-022 SHALL, with EARLY_ABORT=1, go to MISMATCH on the same edge that a bit differing from target[WIDTH-1-count] is entered.
REQ-023 SHALL, when count reaches WIDTH, go to MATCH if entry==target, else to MISMATCH.
REQ-024 SHALL hold LED_G=1 for exactly HOLD_CYCLES cycles in MATCH, clear fail_cnt, then return to IDLE with entry=0 and count=0.
REQ-025 SHALL hold LED_R=1 for HOLD_CYCLES cycles in MISMATCH and increment fail_cnt; if the new fail_cnt==MAX_FAIL go to LOCKOUT, else to IDLE with entry and count cleared.
REQ-026 SHALL, in LOCKOUT, hold LED_R=1 and locked=1 for LOCK_CYCLES cycles, then go to IDLE with fail_cnt=0.
REQ-027 SHALL ignore press pulses in MATCH, MISMATCH and LOCKOUT.
REQ-028 SHALL, with enable=1 in any state except LOCKOUT, load target<=switch, clear entry, count and fail_cnt, and force IDLE; enable has priority over a same-cycle press.
REQ-029 SHALL ignore enable in LOCKOUT.
REQ-030 SHALL make the count register $clog2(WIDTH+1) bits wide; the hold and lock counters SHALL saturate, never wrap.
REQ-031 SHALL drive seg, with select=1, from target: 0 -> 1000000, 1 -> 1111001.
REQ-032 SHALL drive seg, with select=0, from entered bits using the same encoding, and show not-yet-entered positions blank (1111111).
REQ-033 SHALL derive seg combinationally from registered state (zero added latency).

Reset
REQ-034 SHALL, while rst_n=0, immediately force state=IDLE, target=0, entry=0, count=0, fail_cnt=0, all timers 0, and synchroniser flops=1 (released).
REQ-035 SHALL hold LED_G=0, LED_R=0, locked=0 during reset, with seg showing all blank when select=0 and all 0 digits when select=1.
REQ-036 SHALL, on reset mid-entry or mid-lockout, abandon that operation with no LED pulse after release.

Structure
REQ-037 SHALL place the state enum and the segment constants SEG_ZERO, SEG_ONE and SEG_BLANK in shared package code_entry_pkg.
REQ-038 SHALL implement the synchroniser and edge detector as one sub-module btn_edge, instantiated once per button.

Verification (WIDTH=8, HOLD_CYCLES=4, MAX_FAIL=3, LOCK_CYCLES=10)
REQ-039 SHALL cover: load 0xA5 and enter 1,0,1,0,0,1,0,1 -> LED_G high exactly 4 cycles, then IDLE with digits blank.
REQ-040 SHALL cover: EARLY_ABORT=1, target 0xA5, enter 1,1 -> MISMATCH on the 2nd bit, LED_R high 4 cycles, fail_cnt=1.
REQ-041 SHALL cover: EARLY_ABORT=0, target 0xA5, enter 0xA4 -> MISMATCH only after the 8th bit.
REQ-042 SHALL cover: three consecutive failures -> locked=1 for 10 cycles, with presses and enable ignored during lockout; then IDLE.
REQ-043 SHALL cover: both buttons pulsed in the same cycle -> count unchanged; enable asserted mid-entry with switch=0x3C -> entry cleared and target=0x3C.
REQ-044 SHALL cover: rst_n asserted asynchronously mid-MATCH -> LED_G drops immediately, and all outputs match reset values with no clock edge.
